alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle 16×16 multiply sequencer that time-shares the existing combinational 16-bit ALU (zx/nx/zy/ny/f/no control, zr/ng flags). It runs shift-and-add multiplication by driving the ALU operands and control bits one operation per clock, then returns the low 16 bits of the product with zero and negative flags. It sits beside the ALU in the CPU datapath. The ALU itself is instantiated by the parent, and the sequencer reaches it only through its ports.

## Interface
Parameters:
- WIDTH, 16, operand/product width; equals the ALU width, and no other value is supported.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- a  in  16  multiplicand, captured on the accepted start edge.
- b  in  16  multiplier, captured on the accepted start edge.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- done  out  1  one-cycle pulse; `result`, `res_zr` and `res_ng` are valid from this cycle.
- result  out  16  product mod 2^16; held until the next accepted start.
- res_zr  out  1  1 when `result` == 0.
- res_ng  out  1  equals `result[15]`.
- alu_x  out  16  operand driven to ALU x.
- alu_y  out  16  operand driven to ALU y.
- alu_ctl  out  6  {zx,nx,zy,ny,f,no} driven to the ALU.
- alu_out  in  16  ALU result (combinational, same cycle).
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.

## Operation
- Internal registers:
  - acc (16): running product.
  - mcand (16): shifted multiplicand.
  - mplier (16): remaining multiplier bits.
  - cnt (4): bit index.
- States: IDLE, ADD, DBL, DONE.
- IDLE: alu_x=alu_y=0, alu_ctl=PASS_X. On start=1, latch mcand←a, mplier←b, acc←0, cnt←0, then go to ADD.
- ADD: drive alu_x=acc and alu_y=mcand.
  - alu_ctl is ADD (000010) if mplier[0]=1, else PASS_X (001100).
  - Clock edge: acc←alu_out.
  - If cnt==15, also latch res_zr←alu_zr and res_ng←alu_ng.
  - Next state: DBL.
- DBL: drive alu_x=alu_y=mcand, alu_ctl=ADD.
  - Clock edge: mcand←alu_out, mplier←mplier>>1.
  - If cnt==15, go to DONE and load result←acc; otherwise cnt←cnt+1 and go to ADD.
- DONE: done=1 for exactly one cycle. A start in this cycle is accepted exactly as from IDLE (back-to-back); otherwise go to IDLE.
- start in ADD or DBL is ignored. The operands are not re-latched and there is no error flag.
- Arithmetic is two's-complement mod 2^16, so signed and unsigned low halves are identical. Overflow beyond 16 bits is silently discarded.
- All 16 bits are always processed; there is no early exit.

## Timing
- Accepted start at edge T:
  - busy=1 for cycles T+1 … T+32 (16 ADD/DBL pairs).
  - done=1 in cycle T+33; result, res_zr and res_ng are valid at T+33 and held afterwards.
- Fixed latency of 33 cycles from start to done. Throughput is one product per 33 cycles with back-to-back starts.
- The ALU path is combinational within one cycle: alu_x/alu_y/alu_ctl → alu_out → register.
- Reset values: state=IDLE, busy=0, done=0, result=0, res_zr=1, res_ng=0, acc/mcand/mplier/cnt=0.
- Reset asserted mid-operation aborts immediately (asynchronously). No done pulse is produced for the aborted operation, and the first start after reset deasserts is handled normally.
- Simultaneous start and reset: reset wins.

## Structure
- Shared package alu_pkg:
  - ALU control constants ALU_ADD=6'b000010 and ALU_PASS_X=6'b001100, both reusable by the CPU decoder.
  - State encoding constants for IDLE/ADD/DBL/DONE.
- One RTL module, with no sub-modules: the controller and its registers only. The ALU stays outside.
- A bench-only top, alu_mul_unit, instantiates ALU plus alu_mul_seq.

## Test plan
- a=3, b=5, start at T → done at T+33; result=15, res_zr=0, res_ng=0. The alu_ctl sequence in ADD cycles is ADD, PASS_X, ADD, then PASS_X for the remaining bits.
- a=0x0100, b=0x0100 → result=0x0000, res_zr=1, res_ng=0 (overflow discarded).
- a=0xFFFF, b=0x0002 → result=0xFFFE, res_ng=1, res_zr=0.
- Start with a=7, b=9; pulse start with a=1, b=1 at T+10 → ignored. done at T+33 with result=63.
- Reset asserted at T+12 → busy=0, done=0 and result=0 in the same cycle, with no done at T+33. A new start of a=2, b=2 then yields result=4 after 33 cycles.
- Back-to-back: start held high through the DONE cycle → a second operation begins without returning to IDLE. The second done comes exactly 33 cycles after the first, and busy is low only during each DONE cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//
// Shared definitions for the 16-bit datapath ALU and the blocks that drive
// it. The ALU control words are the {zx,nx,zy,ny,f,no} encodings, so the CPU
// instruction decoder can use the same names as the multiply sequencer.
//
// Contents:
//   ALU_W        datapath width of the combinational ALU
//   ALU_ADD      control word for x + y
//   ALU_PASS_X   control word that passes x through unchanged (x & 0xFFFF)
//   mul_state_e  state encoding of the multiply sequencer
//   MUL_LAST_BIT index of the final multiplier bit
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [5:0] ALU_ADD    = 6'b000010;
    localparam logic [5:0] ALU_PASS_X = 6'b001100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DBL  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    localparam logic [3:0] MUL_LAST_BIT = 4'd15;

endpackage

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//
// Multi-cycle 16x16 shift-and-add multiplier that borrows the CPU's
// combinational ALU. Each multiplier bit takes two clocks. In ADD the
// running product either absorbs the shifted multiplicand or passes through
// unchanged. In DBL the multiplicand is doubled by adding it to itself.
// The low 16 bits of the product come out with zero/negative flags after a
// fixed 33 cycles.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset, clears all state
//   start    in   request; only looked at in IDLE or DONE
//   a, b     in   multiplicand / multiplier, captured on an accepted start
//   busy     out  high while the ADD/DBL sequence is running
//   done     out  one-cycle pulse, result and flags are valid from here on
//   result   out  product mod 2^16, held until the next operation finishes
//   res_zr   out  result == 0
//   res_ng   out  result[15]
//   alu_x    out  ALU x operand
//   alu_y    out  ALU y operand
//   alu_ctl  out  ALU control {zx,nx,zy,ny,f,no}
//   alu_out  in   ALU result, combinational in the same cycle
//   alu_zr   in   ALU zero flag
//   alu_ng   in   ALU negative flag
// ---------------------------------------------------------------------------
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             res_zr,
    output logic             res_ng,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng
);

    mul_state_e       state;
    mul_state_e       next_state;
    logic             accept;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [3:0]       cnt;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and ALU drive. DONE behaves like IDLE for a new start, so
    // back-to-back products skip the idle cycle.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        alu_x      = '0;
        alu_y      = '0;
        alu_ctl    = ALU_PASS_X;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_ADD;
                end
            end
            ST_ADD: begin
                busy       = 1'b1;
                alu_x      = acc;
                alu_y      = mcand;
                alu_ctl    = mplier[0] ? ALU_ADD : ALU_PASS_X;
                next_state = ST_DBL;
            end
            ST_DBL: begin
                busy       = 1'b1;
                alu_x      = mcand;
                alu_y      = mcand;
                alu_ctl    = ALU_ADD;
                next_state = (cnt == MUL_LAST_BIT) ? ST_DONE : ST_ADD;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_ADD;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. The flags are taken from the ALU on the last ADD,
    // because that ALU output is exactly the final product. The product
    // itself moves into result on the last DBL, when acc already holds it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            res_zr <= 1'b1;
            res_ng <= 1'b0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
        end else begin
            case (state)
                ST_ADD: begin
                    acc <= alu_out;
                    if (cnt == MUL_LAST_BIT) begin
                        res_zr <= alu_zr;
                        res_ng <= alu_ng;
                    end
                end
                ST_DBL: begin
                    mcand  <= alu_out;
                    mplier <= mplier >> 1;
                    if (cnt == MUL_LAST_BIT) begin
                        result <= acc;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_seq
//
// Bench for alu_mul_seq with a behavioural model of the 16-bit ALU wired to
// its ALU ports. Expected products come from plain multiplication mod 2^16.
// ---------------------------------------------------------------------------
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        res_zr;
    logic        res_ng;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctl;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;

    int errors;
    int checks;

    alu_mul_seq #(.WIDTH(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .res_zr  (res_zr),
        .res_ng  (res_ng),
        .alu_x   (alu_x),
        .alu_y   (alu_y),
        .alu_ctl (alu_ctl),
        .alu_out (alu_out),
        .alu_zr  (alu_zr),
        .alu_ng  (alu_ng)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU: zero/negate each input, add or AND, optionally negate.
    always_comb begin
        logic [15:0] xv;
        logic [15:0] yv;
        logic [15:0] ov;
        xv = alu_ctl[5] ? 16'h0000 : alu_x;
        xv = alu_ctl[4] ? ~xv : xv;
        yv = alu_ctl[3] ? 16'h0000 : alu_y;
        yv = alu_ctl[2] ? ~yv : yv;
        ov = alu_ctl[1] ? (xv + yv) : (xv & yv);
        ov = alu_ctl[0] ? ~ov : ov;
        alu_out = ov;
        alu_zr  = (ov == 16'h0000);
        alu_ng  = ov[15];
    end

    // Low half of the product from plain arithmetic.
    function automatic logic [15:0] refProduct(input logic [15:0] av, input logic [15:0] bv);
        logic [31:0] full;
        full = {16'h0000, av} * {16'h0000, bv};
        return full[15:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] av, input logic [15:0] bv);
        start = s;
        a     = av;
        b     = bv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Walks the operation from cycle lat0 (cycle 1 is the first after the
    // accepted start) until done or a bound. Along the way checks busy and
    // the ALU drive against the partial products implied by a and b.
    task automatic waitDone(input int lat0, input logic [15:0] av, input logic [15:0] bv,
                            output int lat, output int busyErr, output int driveErr,
                            output logic [15:0] addMask);
        int          idx;
        logic [31:0] lowBits;
        logic [15:0] expAcc;
        logic [15:0] expMcand;
        lat      = lat0;
        busyErr  = 0;
        driveErr = 0;
        addMask  = '0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busyErr++;
            if (lat >= 1 && lat <= 32) begin
                idx      = (lat - 1) / 2;
                lowBits  = (32'd1 << idx) - 32'd1;
                expAcc   = refProduct(av, bv & lowBits[15:0]);
                expMcand = av << idx;
                if (lat % 2 == 1) begin
                    addMask[idx] = (alu_ctl == ALU_ADD);
                    if (alu_ctl != ALU_ADD && alu_ctl != ALU_PASS_X) driveErr++;
                    if (alu_x !== expAcc || alu_y !== expMcand) driveErr++;
                end else begin
                    if (alu_ctl !== ALU_ADD || alu_x !== expMcand || alu_y !== expMcand) driveErr++;
                end
            end
            tick();
            lat++;
        end
    endtask

    task automatic checkProduct(input string tag, input logic [15:0] av, input logic [15:0] bv);
        logic [15:0] exp;
        exp = refProduct(av, bv);
        checkOutput({tag, "_result"}, 32'(result), 32'(exp));
        checkOutput({tag, "_zr"}, 32'(res_zr), 32'(exp == 16'h0000));
        checkOutput({tag, "_ng"}, 32'(res_ng), 32'(exp[15]));
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          lat;
        int          busyErr;
        int          driveErr;
        int          donePulses;
        logic [15:0] addMask;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] ra2;
        logic [15:0] rb2;

        errors = 0;
        checks = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        tick();
        tick();

        // Reset state.
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_zr", 32'(res_zr), 32'd1);
        checkOutput("rst_ng", 32'(res_ng), 32'd0);
        checkOutput("rst_ctl", 32'(alu_ctl), 32'(ALU_PASS_X));
        checkOutput("rst_x", 32'({alu_x, alu_y}), 32'd0);
        reset = 1'b0;
        tick();

        // 3 * 5, with the ADD-cycle control pattern following the bits of b.
        applyStimulus(1'b1, 16'd3, 16'd5);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0);
        waitDone(1, 16'd3, 16'd5, lat, busyErr, driveErr, addMask);
        checkOutput("m3x5_latency", 32'(lat), 32'd33);
        checkOutput("m3x5_busy", 32'(busyErr), 32'd0);
        checkOutput("m3x5_drive", 32'(driveErr), 32'd0);
        checkOutput("m3x5_ctlseq", 32'(addMask), 32'h0005);
        checkProduct("m3x5", 16'd3, 16'd5);
        checkOutput("m3x5_result_const", 32'(result), 32'd15);
        tick();
        checkOutput("m3x5_done_pulse", 32'(done), 32'd0);
        checkOutput("m3x5_hold", 32'(result), 32'd15);

        // Overflow wraps to zero.
        applyStimulus(1'b1, 16'h0100, 16'h0100);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0);
        waitDone(1, 16'h0100, 16'h0100, lat, busyErr, driveErr, addMask);
        checkOutput("ovf_latency", 32'(lat), 32'd33);
        checkProduct("ovf", 16'h0100, 16'h0100);
        tick();

        // Negative result.
        applyStimulus(1'b1, 16'hFFFF, 16'h0002);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0);
        waitDone(1, 16'hFFFF, 16'h0002, lat, busyErr, driveErr, addMask);
        checkOutput("neg_latency", 32'(lat), 32'd33);
        checkProduct("neg", 16'hFFFF, 16'h0002);
        checkOutput("neg_result_const", 32'(result), 32'hFFFE);
        tick();

        // A start pulse in the middle of an operation is ignored.
        applyStimulus(1'b1, 16'd7, 16'd9);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0);
        waitDone(1, 16'd7, 16'd9, lat, busyErr, driveErr, addMask);
        checkOutput("ign_latency", 32'(lat), 32'd33);
        checkOutput("ign_result", 32'(result), 32'd63);
        checkOutput("ign_drive", 32'(driveErr), 32'd0);
        tick();

        applyStimulus(1'b1, 16'd7, 16'd9);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0);
        for (int i = 1; i < 10; i++) tick();
        applyStimulus(1'b1, 16'd1, 16'd1);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0);
        waitDone(11, 16'd7, 16'd9, lat, busyErr, driveErr, addMask);
        checkOutput("ign2_latency", 32'(lat), 32'd33);
        checkOutput("ign2_busy", 32'(busyErr), 32'd0);
        checkOutput("ign2_drive", 32'(driveErr), 32'd0);
        checkProduct("ign2", 16'd7, 16'd9);
        tick();

        // Reset in the middle of an operation aborts it.
        applyStimulus(1'b1, 16'd7, 16'd9);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0);
        for (int i = 1; i < 12; i++) tick();
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_result", 32'(result), 32'd0);
        checkOutput("abort_zr", 32'(res_zr), 32'd1);
        tick();
        reset = 1'b0;
        donePulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) donePulses++;
            tick();
        end
        checkOutput("abort_no_done", 32'(donePulses), 32'd0);

        applyStimulus(1'b1, 16'd2, 16'd2);
        tick();
        applyStimulus(1'b0, 16'd0, 16'd0);
        waitDone(1, 16'd2, 16'd2, lat, busyErr, driveErr, addMask);
        checkOutput("after_rst_latency", 32'(lat), 32'd33);
        checkOutput("after_rst_result", 32'(result), 32'd4);
        tick();

        // Back-to-back: start held through DONE chains a second product.
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        ra2 = 16'($urandom);
        rb2 = 16'($urandom);
        applyStimulus(1'b1, ra, rb);
        tick();
        waitDone(1, ra, rb, lat, busyErr, driveErr, addMask);
        checkOutput("b2b1_latency", 32'(lat), 32'd33);
        checkOutput("b2b1_busy", 32'(busyErr), 32'd0);
        checkOutput("b2b1_drive", 32'(driveErr), 32'd0);
        checkProduct("b2b1", ra, rb);
        applyStimulus(1'b1, ra2, rb2);
        tick();
        waitDone(1, ra2, rb2, lat, busyErr, driveErr, addMask);
        applyStimulus(1'b0, 16'd0, 16'd0);
        checkOutput("b2b2_latency", 32'(lat), 32'd33);
        checkOutput("b2b2_busy", 32'(busyErr), 32'd0);
        checkOutput("b2b2_drive", 32'(driveErr), 32'd0);
        checkOutput("b2b2_ctlseq", 32'(addMask), 32'(rb2));
        checkProduct("b2b2", ra2, rb2);
        tick();
        checkOutput("b2b2_idle", 32'(done), 32'd0);

        // Random operands against the arithmetic model.
        for (int n = 0; n < 8; n++) begin
            ra = 16'($urandom);
            rb = (n == 0) ? 16'hFFFF : 16'($urandom);
            applyStimulus(1'b1, ra, rb);
            tick();
            applyStimulus(1'b0, 16'd0, 16'd0);
            waitDone(1, ra, rb, lat, busyErr, driveErr, addMask);
            checkOutput("rnd_latency", 32'(lat), 32'd33);
            checkOutput("rnd_drive", 32'(driveErr), 32'd0);
            checkProduct("rnd", ra, rb);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
